output_scaler: RTL and testbench
================================

// Module: output_scaler
// PURPOSE
//  Inverse of the ADC-side input scaler: maps an 8-bit signed spin amplitude from the FPGA
//  logic to a signed 16-bit DAC code via a 256-entry LUT programmed over gpio_in. Each accepted
//  value becomes a DAC pulse of programmable length, then the output returns to an idle code.
//  Sits between the Ising update logic and the DAC stream.
// PARAMETERS
//  start_addr  0   base config address; owns start_addr..start_addr+4
//  HOLD_W      8   width of pulse-hold counter
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous active-low reset
//  gpio_in      in   32  config bus: [31:24] addr, [23:8] data, [0] write strobe
//  in_val       in   8   signed spin amplitude (-128..127)
//  in_valid     in   1   in_val qualifier
//  in_ready     out  1   block can accept in_val this cycle
//  dac_data     out  16  signed DAC code
//  dac_valid    out  1   high while a pulse is being driven
// BEHAVIOUR
//  Config write: fires on the 0->1 edge of gpio_in[0]. Edge detect is registered, so the
//  write takes effect 1 cycle after the edge. Addresses outside start_addr..+4 are ignored.
//   +0 LUT_PTR   : ptr <= data[7:0]
//   +1 LUT_DATA  : lut[ptr] <= data; ptr <= ptr+1 (wraps 255->0)
//   +2 HOLD_LEN  : hold <= data[HOLD_W-1:0]; value 0 is treated as 1
//   +3 IDLE_CODE : code driven on dac_data when not pulsing
//   +4 OFFSET    : only with SCALER_OFFSET_EN, see CONFIGURATION
//  Config reset values: ptr=0, lut=0, hold=1, idle=0.
//  Output reset values: in_ready=0, dac_data=0, dac_valid=0. in_ready rises 1 cycle after
//  rst deasserts.
//  FSM:
//   IDLE: in_ready=1, dac_data=idle_code, dac_valid=0.
//         in_valid -> LOOKUP; latch idx = in_val + 128 (offset binary; -128->0, 127->255).
//   LOOKUP: in_ready=0; registered LUT read of lut[idx]. One cycle -> PULSE, cnt=hold-1.
//   PULSE: dac_data=code, dac_valid=1. cnt decrements; at cnt==0 -> IDLE.
//  Latency: in_valid accepted at edge N gives dac_valid=1 from edge N+2.
//  dac_valid lasts exactly hold cycles; throughput is one sample per hold+2 cycles.
//  in_valid while in_ready=0 is ignored; no buffering.
//  HOLD_LEN written mid-pulse affects the next pulse only.
//  LUT write to the index being read in LOOKUP on the same cycle: read returns old data.
//  IDLE_CODE written mid-pulse takes effect on return to IDLE.
//  Reset mid-pulse: dac_valid=0 and dac_data=0 at once; FSM returns to IDLE.
//  Config registers return to reset values.
// CONFIGURATION
//  SCALER_OFFSET_EN defined:
//   - adds the OFFSET register at +4 (signed 16, reset 0).
//   - PULSE code = sat16(lut[idx] + offset), using a 17-bit signed sum clamped to
//     [-32768, 32767].
//   - the add is registered: one extra state (ADD) between LOOKUP and PULSE.
//   - latency becomes N+3; throughput is one sample per hold+3 cycles.
//  Undefined: no OFFSET register; writes to +4 are ignored; code = lut[idx].
// TESTING
//  1 reset, no writes; in_val=5 -> dac_valid=1 for 1 cycle at N+2 with dac_data=0;
//    then dac_data=idle=0.
//  2 ptr=0x7E, then LUT_DATA 0x1234 and 0xABCD (auto-inc); in_val=-2 -> 0x1234,
//    in_val=-1 -> 0xABCD.
//  3 ptr=255, two LUT_DATA writes -> entries 255 and 0 written (wrap).
//  4 hold=4, idle=0x0100; in_valid held high for 20 cycles -> pulses of exactly 4 cycles;
//    in_ready low for 5 cycles per sample; dac_data=0x0100 between pulses.
//  5 assert rst mid-pulse -> dac_valid=0 and dac_data=0 immediately; after release, lut
//    reads back 0.
//  6 SCALER_OFFSET_EN, lut=0x7FF0, offset=0x0100 -> 0x7FFF; lut=0x8010, offset=-0x100
//    -> 0x8000; latency N+3.

Source files
------------

// File: rtl/output_scaler.sv
// Spin-amplitude to DAC-code scaler: 256-entry LUT programmed over gpio_in, pulsed output with idle code.
// Optional SCALER_OFFSET_EN adds a signed offset register and a saturating add stage.
module output_scaler #(
    parameter logic [7:0] start_addr = 8'd0,
    parameter int         HOLD_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       gpio_in,
    input  logic signed [7:0] in_val,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [15:0]       dac_data,
    output logic              dac_valid
);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_ADD, S_PULSE} state_t;

    state_t              state, state_nxt;
    logic                strobe_q, wr_pend;
    logic [7:0]          wr_addr;
    logic [15:0]         wr_data;
    logic [8:0]          rel;
    logic [7:0]          ptr;
    logic [15:0]         lut [256];
    logic [HOLD_W-1:0]   hold, hold_eff, cnt;
    logic [15:0]         idle_code;
    logic [7:0]          idx;
    logic [15:0]         code;
    logic                accept;
    logic                ready_nxt, valid_nxt;
    logic [15:0]         data_nxt;
    logic                unused_gpio;

    assign unused_gpio = ^gpio_in[7:1];
    // Underflow makes rel >= 256, so anything below start_addr falls into the default arm.
    assign rel      = {1'b0, wr_addr} - {1'b0, start_addr};
    assign hold_eff = (hold == '0) ? HOLD_W'(1) : hold;
    assign accept   = in_valid && in_ready;

`ifdef SCALER_OFFSET_EN
    logic [15:0] offset, rd;
    logic [16:0] sum;
    logic [15:0] sat;
    assign sum = {rd[15], rd} + {offset[15], offset};
    assign sat = (sum[16] != sum[15]) ? (sum[16] ? 16'h8000 : 16'h7FFF) : sum[15:0];
`endif

    // Config bus: strobe edge and payload are registered, write lands one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strobe_q  <= 1'b0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            ptr       <= '0;
            hold      <= HOLD_W'(1);
            idle_code <= '0;
            for (int i = 0; i < 256; i++) lut[i] <= '0;
`ifdef SCALER_OFFSET_EN
            offset    <= '0;
`endif
        end else begin
            strobe_q <= gpio_in[0];
            wr_pend  <= gpio_in[0] & ~strobe_q;
            wr_addr  <= gpio_in[31:24];
            wr_data  <= gpio_in[23:8];
            if (wr_pend) begin
                case (rel)
                    9'd0: ptr <= wr_data[7:0];
                    9'd1: begin
                        lut[ptr] <= wr_data;
                        ptr      <= ptr + 8'd1;
                    end
                    9'd2: hold <= wr_data[HOLD_W-1:0];
                    9'd3: idle_code <= wr_data;
`ifdef SCALER_OFFSET_EN
                    9'd4: offset <= wr_data;
`endif
                    default: ;
                endcase
            end
        end
    end

    // State register plus the datapath registers it sequences.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= '0;
            code  <= '0;
            cnt   <= '0;
`ifdef SCALER_OFFSET_EN
            rd    <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (accept) idx <= in_val ^ 8'h80;  // offset binary: -128 -> 0
                S_LOOKUP: begin
`ifdef SCALER_OFFSET_EN
                    rd   <= lut[idx];
`else
                    code <= lut[idx];
`endif
                    cnt  <= hold_eff - HOLD_W'(1);
                end
                S_ADD: begin
`ifdef SCALER_OFFSET_EN
                    code <= sat;
`endif
                    cnt  <= hold_eff - HOLD_W'(1);
                end
                S_PULSE: if (cnt != '0) cnt <= cnt - HOLD_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_LOOKUP;
`ifdef SCALER_OFFSET_EN
            S_LOOKUP: state_nxt = S_ADD;
`else
            S_LOOKUP: state_nxt = S_PULSE;
`endif
            S_ADD:    state_nxt = S_PULSE;
            S_PULSE:  if (cnt == '0) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready_nxt = (state_nxt == S_IDLE);
        valid_nxt = (state == S_PULSE);
        data_nxt  = (state == S_PULSE) ? code : idle_code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b0;
            dac_valid <= 1'b0;
            dac_data  <= '0;
        end else begin
            in_ready  <= ready_nxt;
            dac_valid <= valid_nxt;
            dac_data  <= data_nxt;
        end
    end

endmodule

// File: tb/tb_output_scaler.sv
// Bench for output_scaler: table vectors, hand sequences for multi-cycle corners, random traffic vs a LUT model.
// Define SCALER_OFFSET_EN for both bench and RTL to cover the offset build.
module tb_output_scaler;

`ifdef SCALER_OFFSET_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       gpio_in = '0;
    logic signed [7:0] in_val = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       dac_data;
    logic              dac_valid;

    output_scaler dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .in_val(in_val), .in_valid(in_valid),
        .in_ready(in_ready), .dac_data(dac_data), .dac_valid(dac_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the configuration state as the programmer sees it.
    logic [15:0] lut_m [256];
    logic [7:0]  ptr_m;
    logic [7:0]  hold_m;
    logic [15:0] idle_m;
    logic [15:0] off_m;

    typedef struct {
        logic signed [7:0] val;
        logic [15:0]       entry;
        logic [7:0]        hold;
        logic [15:0]       idle;
        logic [15:0]       exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) lut_m[i] = '0;
        ptr_m = '0; hold_m = 8'd1; idle_m = '0; off_m = '0;
    endtask

    function automatic logic [15:0] exp_code(input logic signed [7:0] v);
        int s;
        s = int'($signed(lut_m[int'(v) + 128]));
`ifdef SCALER_OFFSET_EN
        s = s + int'($signed(off_m));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return 16'(s);
    endfunction

    task automatic cfg_write(input logic [7:0] a, input logic [15:0] d);
        gpio_in = {a, d, 7'd0, 1'b1};
        @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        case (a)
            8'd0: ptr_m = d[7:0];
            8'd1: begin lut_m[ptr_m] = d; ptr_m = ptr_m + 8'd1; end
            8'd2: hold_m = d[7:0];
            8'd3: idle_m = d;
`ifdef SCALER_OFFSET_EN
            8'd4: off_m = d;
`endif
            default: ;
        endcase
    endtask

    // Send one sample and check every cycle from acceptance to return to idle.
    task automatic run_sample(input string name, input logic signed [7:0] v, input logic [15:0] code);
        int  h, w;
        logic vexp;
        h = (hold_m == 0) ? 1 : int'(hold_m);
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        in_val = v; in_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= LAT + h; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            vexp = (k >= LAT) && (k < LAT + h);
            check({name, "_valid"}, 32'(dac_valid), 32'(vexp));
            check({name, "_data"}, 32'(dac_data), 32'(vexp ? code : idle_m));
        end
    endtask

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{val: -8'sd128, entry: 16'h8000, hold: 8'd1, idle: 16'h0000, exp: 16'h8000};
        vecs[1] = '{val:  8'sd127, entry: 16'h7FFF, hold: 8'd2, idle: 16'h0055, exp: 16'h7FFF};
        vecs[2] = '{val:  8'sd0,   entry: 16'hBEEF, hold: 8'd3, idle: 16'hFFFF, exp: 16'hBEEF};
        vecs[3] = '{val:  8'sd37,  entry: 16'h0001, hold: 8'd0, idle: 16'h1111, exp: 16'h0001};
        vecs[4] = '{val: -8'sd77,  entry: 16'hC3A5, hold: 8'd5, idle: 16'h0000, exp: 16'hC3A5};
        model_reset();

        // Reset state and in_ready rising one cycle after release.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(dac_valid), 32'd0);
        check("rst_data", 32'(dac_data), 32'd0);
        rst = 1'b1;
        #1 check("rel_ready_early", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rel_ready", 32'(in_ready), 32'd1);

        run_sample("t1", 8'sd5, 16'h0000);

        cfg_write(8'd0, 16'h007E);
        cfg_write(8'd1, 16'h1234);
        cfg_write(8'd1, 16'hABCD);
        run_sample("t2a", -8'sd2, 16'h1234);
        run_sample("t2b", -8'sd1, 16'hABCD);

        cfg_write(8'd0, 16'h00FF);
        cfg_write(8'd1, 16'h5555);
        cfg_write(8'd1, 16'h6666);
        run_sample("t3a", 8'sd127, 16'h5555);
        run_sample("t3b", -8'sd128, 16'h6666);

        for (int i = 0; i < 5; i++) begin
            cfg_write(8'd0, 16'(int'(vecs[i].val) + 128));
            cfg_write(8'd1, vecs[i].entry);
            cfg_write(8'd2, {8'd0, vecs[i].hold});
            cfg_write(8'd3, vecs[i].idle);
            run_sample($sformatf("vec%0d", i), vecs[i].val, vecs[i].exp);
        end

        // Back-to-back traffic with in_valid held high.
        begin
            int vrun, rrun, pulses, w;
            logic [15:0] pc;
            cfg_write(8'd0, 16'd128);
            cfg_write(8'd1, 16'h4242);
            cfg_write(8'd2, 16'd4);
            cfg_write(8'd3, 16'h0100);
            pc = exp_code(8'sd0);
            vrun = 0; rrun = 0; pulses = 0; w = 0;
            while (!in_ready && w < 20) begin @(negedge clk); w++; end
            in_val = 8'sd0; in_valid = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (c == 20) in_valid = 1'b0;
                if (dac_valid) begin
                    vrun++;
                    check("t4_pulse_data", 32'(dac_data), 32'(pc));
                end else begin
                    if (vrun != 0) begin check("t4_pulse_len", 32'(vrun), 32'd4); pulses++; end
                    vrun = 0;
                    check("t4_idle_data", 32'(dac_data), 32'h0100);
                end
                if (!in_ready) rrun++;
                else begin
                    if (rrun != 0) check("t4_busy_len", 32'(rrun), 32'(4 + LAT - 1));
                    rrun = 0;
                end
            end
            check("t4_pulses", 32'(pulses >= 3), 32'd1);
            cfg_write(8'd2, 16'd1);
        end

`ifdef SCALER_OFFSET_EN
        cfg_write(8'd0, 16'd138);
        cfg_write(8'd1, 16'h7FF0);
        cfg_write(8'd4, 16'h0100);
        run_sample("t6a", 8'sd10, 16'h7FFF);
        cfg_write(8'd0, 16'd138);
        cfg_write(8'd1, 16'h8010);
        cfg_write(8'd4, 16'hFF00);
        run_sample("t6b", 8'sd10, 16'h8000);
        cfg_write(8'd4, 16'h0000);
`endif

        // Random configuration traffic (including out-of-range addresses) against the model.
        for (int it = 0; it < 40; it++) begin
            int nw;
            logic [7:0]  a;
            logic [15:0] d;
            logic signed [7:0] v;
            nw = int'($urandom_range(1, 3));
            for (int j = 0; j < nw; j++) begin
                case ($urandom_range(0, 6))
                    0: a = 8'd0;
                    1, 2: a = 8'd1;
                    3: a = 8'd2;
                    4: a = 8'd3;
                    5: a = 8'd4;
                    default: a = 8'($urandom_range(5, 255));
                endcase
                d = 16'($urandom);
                if (a == 8'd2) d = d & 16'h0007;
                cfg_write(a, d);
            end
            v = $urandom_range(0, 1) ? $signed(8'(ptr_m - 8'd1 - 8'd128)) : $signed(8'($urandom));
            run_sample($sformatf("rnd%0d", it), v, exp_code(v));
        end

        // Reset in the middle of a long pulse.
        cfg_write(8'd2, 16'd8);
        in_val = -8'sd2; in_valid = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("t5_pulsing", 32'(dac_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5_valid", 32'(dac_valid), 32'd0);
        check("t5_data", 32'(dac_data), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_sample("t5_lut126", -8'sd2, 16'h0000);
        run_sample("t5_lut255", 8'sd127, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
